hack_boot_ctrl: RTL and testbench

//  Boot/debug sequencer for the Hack CPU. Receives a byte-stream command protocol from a host link.

---
 rtl/hack_boot_ctrl_if.sv | 22 ++
 rtl/hack_boot_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hack_boot_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_boot_ctrl_if.sv
// Host byte-link interface for the Hack boot/debug controller.
//
// Purpose: carries the byte stream from the host UART/FIFO to the controller
// with a valid/ready handshake. A byte is transferred on a rising clock edge
// when rx_valid and rx_ready are both high.
//
// Signals:
//   rx_data   host byte
//   rx_valid  rx_data holds a byte to transfer
//   rx_ready  receiver can take a byte this cycle
//
// Modports:
//   master  host side (drives rx_data/rx_valid, observes rx_ready)
//   slave   controller side (observes rx_data/rx_valid, drives rx_ready)
interface hack_boot_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/hack_boot_ctrl.sv
// Boot/debug sequencer for the Hack CPU.
//
// Purpose: decodes a byte-stream command protocol from the host, writes
// program words into the instruction ROM while holding the CPU in reset,
// and then runs, halts, single-steps or breakpoints the CPU through its
// reset and clock-enable pins.
//
// Commands (decoded only while the parser is idle):
//   'L' 0x4C  enter HOLD, then 16-bit word count N, then N 16-bit words
//   'R' 0x52  enter RUN (resuming from HALT executes a breakpointed insn once)
//   'H' 0x48  RUN -> HALT
//   'S' 0x53  in HALT, enable the CPU for exactly one cycle
//   'B' 0x42  16-bit breakpoint address, then arm the breakpoint
//   'C' 0x43  disarm the breakpoint
//   other     set the sticky err flag, byte dropped
// Multi-byte fields are big-endian.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   host       byte link (slave modport): rx_data, rx_valid, rx_ready
//   rom_we     ROM write strobe, one cycle per word
//   rom_addr   ROM write address (word index modulo 2^ROM_AW)
//   rom_wdata  ROM write data
//   pc         CPU program counter
//   cpu_reset  active-high CPU reset, high while in HOLD
//   cpu_en     CPU clock enable
//   mode       0=HOLD 1=RUN 2=HALT
//   bp_valid   breakpoint armed
//   err        sticky unknown-command flag
module hack_boot_ctrl #(
  parameter int ROM_AW = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hack_boot_ctrl_if.slave   host,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  input  logic [15:0]       pc,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic [1:0]        mode,
  output logic              bp_valid,
  output logic              err
);

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_BP    = 8'h42;
  localparam logic [7:0] CMD_CLRBP = 8'h43;

  typedef enum logic [1:0] {
    M_HOLD = 2'd0,
    M_RUN  = 2'd1,
    M_HALT = 2'd2
  } modeT;

  typedef enum logic [2:0] {
    P_CMD   = 3'd0,
    P_CNT_H = 3'd1,
    P_CNT_L = 3'd2,
    P_W_H   = 3'd3,
    P_W_L   = 3'd4,
    P_BP_H  = 3'd5,
    P_BP_L  = 3'd6
  } parserT;

  modeT              modeState;
  parserT            parserState;
  logic [7:0]        byteHi;      // high byte of the field being assembled
  logic [15:0]       wordsLeft;   // words still to receive in the current load
  logic [ROM_AW-1:0] wordIdx;     // next ROM address; wraps naturally
  logic [15:0]       bpAddr;
  logic              stepPulse;
  logic              bpSkip;
  logic              bpHit;
  logic              rxFire;
  logic [15:0]       rxField;     // big-endian 16-bit field completed by this byte

  // The only cycle the controller cannot take a byte is the ROM write cycle,
  // which keeps a new word from being assembled while the previous one lands.
  assign host.rx_ready = ~rom_we;
  assign rxFire        = host.rx_valid & host.rx_ready;
  assign rxField       = {byteHi, host.rx_data};

  // bpSkip masks the breakpoint for the first RUN cycle after a resume from
  // HALT, so resuming while parked on the breakpoint executes it once.
  assign bpHit     = bp_valid & (modeState == M_RUN) & (pc == bpAddr) & ~bpSkip;
  assign cpu_reset = (modeState == M_HOLD);
  assign cpu_en    = ((modeState == M_RUN) & ~bpHit) | stepPulse;
  assign mode      = modeState;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modeState   <= M_HOLD;
      parserState <= P_CMD;
      byteHi      <= '0;
      wordsLeft   <= '0;
      wordIdx     <= '0;
      bpAddr      <= '0;
      stepPulse   <= 1'b0;
      bpSkip      <= 1'b0;
      rom_we      <= 1'b0;
      rom_addr    <= '0;
      rom_wdata   <= '0;
      bp_valid    <= 1'b0;
      err         <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      stepPulse <= 1'b0;
      bpSkip    <= 1'b0;

      // A breakpoint hit parks the CPU; a command accepted on the same edge
      // is processed afterwards and therefore takes precedence.
      if (bpHit) begin
        modeState <= M_HALT;
      end

      if (rxFire) begin
        unique case (parserState)
          P_CMD: begin
            case (host.rx_data)
              CMD_LOAD: begin
                modeState   <= M_HOLD;
                parserState <= P_CNT_H;
              end
              CMD_RUN: begin
                if (modeState == M_HALT) begin
                  bpSkip <= 1'b1;
                end
                modeState <= M_RUN;
              end
              CMD_HALT: begin
                if (modeState == M_RUN) begin
                  modeState <= M_HALT;
                end
              end
              CMD_STEP: begin
                if (modeState == M_HALT) begin
                  stepPulse <= 1'b1;
                end
              end
              CMD_BP: begin
                parserState <= P_BP_H;
              end
              CMD_CLRBP: begin
                bp_valid <= 1'b0;
              end
              default: begin
                err <= 1'b1;
              end
            endcase
          end
          P_CNT_H: begin
            byteHi      <= host.rx_data;
            parserState <= P_CNT_L;
          end
          P_CNT_L: begin
            wordsLeft   <= rxField;
            wordIdx     <= '0;
            parserState <= (rxField == 16'd0) ? P_CMD : P_W_H;
          end
          P_W_H: begin
            byteHi      <= host.rx_data;
            parserState <= P_W_L;
          end
          P_W_L: begin
            rom_we      <= 1'b1;
            rom_addr    <= wordIdx;
            rom_wdata   <= DATA_W'(rxField);
            wordIdx     <= wordIdx + ROM_AW'(1);
            wordsLeft   <= wordsLeft - 16'd1;
            parserState <= (wordsLeft == 16'd1) ? P_CMD : P_W_H;
          end
          P_BP_H: begin
            byteHi      <= host.rx_data;
            parserState <= P_BP_L;
          end
          P_BP_L: begin
            bpAddr      <= rxField;
            bp_valid    <= 1'b1;
            parserState <= P_CMD;
          end
          default: begin
            parserState <= P_CMD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Testbench for hack_boot_ctrl: host byte driver, a counting CPU stand-in
// that advances pc whenever the controller enables it, a ROM write monitor,
// and one task per feature with inline comparisons.
module tb_hack_boot_ctrl;

  localparam int AW = 3;   // small ROM so address wrap is reachable quickly
  localparam logic [26:0] RST_VEC = {1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 16'h0000, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          romWe;
  logic [AW-1:0] romAddr;
  logic [15:0]   romWdata;
  logic [15:0]   pc = 16'd0;
  logic          cpuReset;
  logic          cpuEn;
  logic [1:0]    mode;
  logic          bpValid;
  logic          err;

  int errors = 0;
  int checks = 0;
  int readyViol = 0;
  logic [AW+15:0] wrQ[$];

  always #5 clk = ~clk;

  hack_boot_ctrl_if hostIf ();

  hack_boot_ctrl #(.ROM_AW(AW), .DATA_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .host      (hostIf),
    .rom_we    (romWe),
    .rom_addr  (romAddr),
    .rom_wdata (romWdata),
    .pc        (pc),
    .cpu_reset (cpuReset),
    .cpu_en    (cpuEn),
    .mode      (mode),
    .bp_valid  (bpValid),
    .err       (err)
  );

  // CPU stand-in: pc held at 0 in reset, counts one per enabled cycle.
  always @(posedge clk) begin
    if (cpuReset) pc <= 16'd0;
    else if (cpuEn) pc <= pc + 16'd1;
  end

  // ROM write monitor.
  always @(negedge clk) begin
    if (romWe === 1'b1) begin
      wrQ.push_back({romAddr, romWdata});
      if (hostIf.rx_ready !== 1'b0) readyViol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic sendByte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    hostIf.rx_data  = b;
    hostIf.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (hostIf.rx_ready === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    hostIf.rx_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: byte=%02h rx_ready=%b required 1", b, hostIf.rx_ready);
    end else begin
      $display("tx byte=%02h mode=%0d pc=%0d", b, mode, pc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hostIf.rx_valid = 1'b0;
    hostIf.rx_data  = 8'h00;
    waitCycles(3);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpuReset, cpuEn, mode, hostIf.rx_ready, romWe, romAddr, romWdata, bpValid, err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state: got=%h required=%h",
               {cpuReset, cpuEn, mode, hostIf.rx_ready, romWe, romAddr, romWdata, bpValid, err}, RST_VEC);
    end
  endtask

  task automatic test_load_fixed();
    logic [7:0] seq[7];
    seq = '{8'h4C, 8'h00, 8'h02, 8'h01, 8'h2C, 8'hEC, 8'h10};
    wrQ.delete();
    readyViol = 0;
    foreach (seq[i]) sendByte(seq[i]);
    waitCycles(3);
    checks++;
    if (wrQ.size() != 2) begin
      errors++;
      $display("FAIL load_fixed_count: got=%0d required=2", wrQ.size());
    end else begin
      checks++;
      if (wrQ[0] !== {3'd0, 16'h012C}) begin
        errors++;
        $display("FAIL load_fixed_w0: got=%h required=%h", wrQ[0], {3'd0, 16'h012C});
      end
      checks++;
      if (wrQ[1] !== {3'd1, 16'hEC10}) begin
        errors++;
        $display("FAIL load_fixed_w1: got=%h required=%h", wrQ[1], {3'd1, 16'hEC10});
      end
    end
    checks++;
    if (readyViol != 0 || mode !== 2'd0 || cpuReset !== 1'b1) begin
      errors++;
      $display("FAIL load_fixed_ctrl: ready_viol=%0d mode=%0d cpu_reset=%b required 0/0/1",
               readyViol, mode, cpuReset);
    end
  endtask

  task automatic test_load_random();
    for (int r = 0; r < 3; r++) begin
      int n;
      logic [15:0] words[$];
      n = (r == 2) ? 10 : int'($urandom_range(1, 5));
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(16'($urandom));
      wrQ.delete();
      readyViol = 0;
      sendByte(8'h4C);
      sendByte(8'(n >> 8));
      sendByte(8'(n & 255));
      foreach (words[k]) begin
        sendByte(words[k][15:8]);
        sendByte(words[k][7:0]);
      end
      waitCycles(3);
      checks++;
      if (wrQ.size() != n) begin
        errors++;
        $display("FAIL load_rand_count: got=%0d required=%0d", wrQ.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          logic [AW+15:0] expv;
          expv = {AW'(k % (1 << AW)), words[k]};
          checks++;
          if (wrQ[k] !== expv) begin
            errors++;
            $display("FAIL load_rand_word%0d: got=%h required=%h", k, wrQ[k], expv);
          end
        end
      end
      checks++;
      if (readyViol != 0 || mode !== 2'd0) begin
        errors++;
        $display("FAIL load_rand_ctrl: ready_viol=%0d mode=%0d required 0/0", readyViol, mode);
      end
    end
  endtask

  task automatic test_run_halt();
    int k;
    sendByte(8'h52);
    checks++;
    if (mode !== 2'd1 || cpuReset !== 1'b0 || cpuEn !== 1'b1) begin
      errors++;
      $display("FAIL run_start: mode=%0d cpu_reset=%b cpu_en=%b required 1/0/1", mode, cpuReset, cpuEn);
    end
    k = int'($urandom_range(3, 12));
    waitCycles(k);
    checks++;
    if (pc !== 16'(k)) begin
      errors++;
      $display("FAIL run_count: pc=%0d required=%0d", pc, k);
    end
    sendByte(8'h48);
    checks++;
    if (mode !== 2'd2 || cpuEn !== 1'b0 || pc !== 16'(k + 1)) begin
      errors++;
      $display("FAIL halt: mode=%0d cpu_en=%b pc=%0d required 2/0/%0d", mode, cpuEn, pc, k + 1);
    end
    waitCycles(4);
    checks++;
    if (pc !== 16'(k + 1)) begin
      errors++;
      $display("FAIL halt_hold: pc=%0d required=%0d", pc, k + 1);
    end
  endtask

  task automatic test_step();
    int nSteps;
    nSteps = int'($urandom_range(1, 4));
    for (int s = 0; s < nSteps; s++) begin
      logic [15:0] p;
      p = pc;
      sendByte(8'h53);
      checks++;
      if (cpuEn !== 1'b1) begin
        errors++;
        $display("FAIL step_pulse: cpu_en=%b required 1", cpuEn);
      end
      @(negedge clk);
      checks++;
      if (cpuEn !== 1'b0 || pc !== p + 16'd1) begin
        errors++;
        $display("FAIL step_once: cpu_en=%b pc=%0d required 0/%0d", cpuEn, pc, p + 16'd1);
      end
      waitCycles(int'($urandom_range(0, 3)));
      checks++;
      if (pc !== p + 16'd1 || mode !== 2'd2) begin
        errors++;
        $display("FAIL step_after: pc=%0d mode=%0d required %0d/2", pc, mode, p + 16'd1);
      end
    end
    sendByte(8'h52);
    sendByte(8'h53);
    checks++;
    if (mode !== 2'd1 || cpuEn !== 1'b1) begin
      errors++;
      $display("FAIL step_in_run: mode=%0d cpu_en=%b required 1/1", mode, cpuEn);
    end
    sendByte(8'h48);
  endtask

  task automatic test_breakpoint(input int bpA);
    bit sawHit;
    logic enAtHit;
    bit halted;
    sawHit  = 1'b0;
    enAtHit = 1'b1;
    halted  = 1'b0;
    sendByte(8'h4C);
    checks++;
    if (cpuReset !== 1'b1 || mode !== 2'd0) begin
      errors++;
      $display("FAIL bp_load_hold: cpu_reset=%b mode=%0d required 1/0", cpuReset, mode);
    end
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h42);
    sendByte(8'(bpA >> 8));
    sendByte(8'(bpA & 255));
    checks++;
    if (bpValid !== 1'b1 || mode !== 2'd0) begin
      errors++;
      $display("FAIL bp_arm: bp_valid=%b mode=%0d required 1/0", bpValid, mode);
    end
    sendByte(8'h52);
    for (int i = 0; i < 200 && !halted; i++) begin
      if (mode === 2'd2) halted = 1'b1;
      else begin
        if (pc === 16'(bpA)) begin
          sawHit  = 1'b1;
          enAtHit = cpuEn;
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!halted || !sawHit || enAtHit !== 1'b0) begin
      errors++;
      $display("FAIL bp_hit: halted=%b saw_hit=%b cpu_en_at_hit=%b required 1/1/0", halted, sawHit, enAtHit);
    end
    checks++;
    if (pc !== 16'(bpA) || cpuEn !== 1'b0) begin
      errors++;
      $display("FAIL bp_park: pc=%0d cpu_en=%b required %0d/0", pc, cpuEn, bpA);
    end
    waitCycles(3);
    sendByte(8'h52);
    checks++;
    if (mode !== 2'd1 || cpuEn !== 1'b1 || pc !== 16'(bpA)) begin
      errors++;
      $display("FAIL bp_resume: mode=%0d cpu_en=%b pc=%0d required 1/1/%0d", mode, cpuEn, pc, bpA);
    end
    waitCycles(3);
    checks++;
    if (mode !== 2'd1 || pc !== 16'(bpA + 3)) begin
      errors++;
      $display("FAIL bp_continue: mode=%0d pc=%0d required 1/%0d", mode, pc, bpA + 3);
    end
  endtask

  task automatic test_bp_in_run(output logic [15:0] tgt);
    bit halted;
    halted = 1'b0;
    tgt = pc + 16'($urandom_range(8, 20));
    sendByte(8'h42);
    sendByte(tgt[15:8]);
    sendByte(tgt[7:0]);
    checks++;
    if (mode !== 2'd1 || bpValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_run_arm: mode=%0d bp_valid=%b required 1/1", mode, bpValid);
    end
    for (int i = 0; i < 100 && !halted; i++) begin
      if (mode === 2'd2) halted = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!halted || pc !== tgt) begin
      errors++;
      $display("FAIL bp_run_hit: halted=%b pc=%0d required 1/%0d", halted, pc, tgt);
    end
  endtask

  task automatic test_clear_bp(input logic [15:0] tgt);
    bit reached;
    bit leftRun;
    reached = 1'b0;
    leftRun = 1'b0;
    sendByte(8'h43);
    checks++;
    if (bpValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear: bp_valid=%b required 0", bpValid);
    end
    sendByte(8'h52);
    sendByte(8'h4C);
    checks++;
    if (cpuReset !== 1'b1 || mode !== 2'd0) begin
      errors++;
      $display("FAIL load_mid_run: cpu_reset=%b mode=%0d required 1/0", cpuReset, mode);
    end
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h52);
    for (int i = 0; i < 200 && !reached; i++) begin
      if (mode !== 2'd1) leftRun = 1'b1;
      if (pc === tgt + 16'd2) reached = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!reached || leftRun) begin
      errors++;
      $display("FAIL bp_cleared_run: reached=%b left_run=%b required 1/0", reached, leftRun);
    end
    sendByte(8'h48);
  endtask

  task automatic test_err_reset();
    wrQ.delete();
    sendByte(8'h4C);
    sendByte(8'h00);
    sendByte(8'h00);
    waitCycles(3);
    checks++;
    if (wrQ.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: writes=%0d err=%b required 0/0", wrQ.size(), err);
    end
    sendByte(8'h7A);
    checks++;
    if (err !== 1'b1 || mode !== 2'd0) begin
      errors++;
      $display("FAIL err_set: err=%b mode=%0d required 1/0", err, mode);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      while (b == 8'h4C || b == 8'h52 || b == 8'h48 || b == 8'h53 || b == 8'h42 || b == 8'h43)
        b = 8'($urandom_range(0, 255));
      sendByte(b);
      checks++;
      if (err !== 1'b1 || mode !== 2'd0) begin
        errors++;
        $display("FAIL err_sticky: byte=%02h err=%b mode=%0d required 1/0", b, err, mode);
      end
    end
    wrQ.delete();
    sendByte(8'h4C);
    sendByte(8'h00);
    sendByte(8'h03);
    sendByte(8'h12);
    sendByte(8'h34);
    sendByte(8'h56);
    checks++;
    if (wrQ.size() != 1) begin
      errors++;
      $display("FAIL partial_load: writes=%0d required 1", wrQ.size());
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cpuReset, cpuEn, mode, hostIf.rx_ready, romWe, romAddr, romWdata, bpValid, err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_mid_load: got=%h required=%h",
               {cpuReset, cpuEn, mode, hostIf.rx_ready, romWe, romAddr, romWdata, bpValid, err}, RST_VEC);
    end
    waitCycles(2);
    reset_n = 1'b1;
    @(negedge clk);
    sendByte(8'h52);
    checks++;
    if (mode !== 2'd1 || cpuReset !== 1'b0) begin
      errors++;
      $display("FAIL parser_after_reset: mode=%0d cpu_reset=%b required 1/0", mode, cpuReset);
    end
  endtask

  initial begin
    logic [15:0] tgt;
    hostIf.rx_valid = 1'b0;
    hostIf.rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_load_fixed();
    test_load_random();
    test_run_halt();
    test_step();
    test_breakpoint(5);
    test_breakpoint(int'($urandom_range(3, 30)));
    test_bp_in_run(tgt);
    test_clear_bp(tgt);
    test_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
